// File: rtl/restroom_pkg.sv
// -----------------------------------------------------------------------------
// restroom_pkg
//   Shared types and constants for the smart restroom controller.
//   - stall_state_t : per-stall sequencing state
//   - USAGE_W       : width of the completed-entry counter (usage_cnt), which
//                     only exists when RESTROOM_USAGE_CNT_EN is defined
// -----------------------------------------------------------------------------
package restroom_pkg;

    typedef enum logic [2:0] {
        VACANT   = 3'd0,
        ARMED    = 3'd1,
        ENTER    = 3'd2,
        OCCUPIED = 3'd3,
        FLUSHED  = 3'd4,
        EXIT     = 3'd5
    } stall_state_t;

    localparam int USAGE_W = 16;

endpackage : restroom_pkg

// File: rtl/restroom_stall_fsm.sv
// -----------------------------------------------------------------------------
// restroom_stall_fsm
//   Sequencer for one stall: pre-entry flush arms the stall, an outside door
//   request opens the door for DOOR_CYC cycles, the occupant must flush before
//   the inside door request is honoured, and the exit door is held open for
//   DOOR_CYC cycles. An occupancy timer raises a sticky alarm after
//   OCC_TIMEOUT cycles in OCCUPIED/FLUSHED; the alarm clears on return to
//   VACANT.
//
//   Optional feature macro: RESTROOM_USAGE_CNT_EN adds the enter_done output.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   water_ok            1 = tank is not requesting a refill
//   flush_out           outside pre-entry flush button
//   door_open_outside   outside door request
//   flush_in            inside flush button
//   door_open_inside    inside door request
//   door_state          1 = door open (registered)
//   light               stall light (registered)
//   occupied            occupancy indicator (registered)
//   alarm               occupancy timeout, sticky until VACANT (registered)
//   enter_done          (macro only) stall takes ENTER->OCCUPIED this cycle
//   state               current state, exposed for popcount and debug
// -----------------------------------------------------------------------------
module restroom_stall_fsm
    import restroom_pkg::*;
#(
    parameter int DOOR_CYC    = 8,
    parameter int OCC_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         water_ok,
    input  logic         flush_out,
    input  logic         door_open_outside,
    input  logic         flush_in,
    input  logic         door_open_inside,
    output logic         door_state,
    output logic         light,
    output logic         occupied,
    output logic         alarm,
`ifdef RESTROOM_USAGE_CNT_EN
    output logic         enter_done,
`endif
    output stall_state_t state
);

    localparam int DT_W = $clog2(DOOR_CYC + 1);
    localparam int OT_W = $clog2(OCC_TIMEOUT + 1);

    // Door/arm timer counts 0..DOOR_CYC-1; the transition fires on the edge
    // where it already holds DOOR_CYC-1, giving exactly DOOR_CYC cycles.
    localparam logic [DT_W-1:0] DOOR_LAST = DT_W'(DOOR_CYC - 1);
    localparam logic [OT_W-1:0] OCC_LAST  = OT_W'(OCC_TIMEOUT - 1);
    localparam logic [OT_W-1:0] OCC_MAX   = OT_W'(OCC_TIMEOUT);

    logic [DT_W-1:0] door_tmr;
    logic [OT_W-1:0] occ_tmr;

`ifdef RESTROOM_USAGE_CNT_EN
    assign enter_done = (state == ENTER) && (door_tmr == DOOR_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= VACANT;
            door_tmr   <= '0;
            occ_tmr    <= '0;
            door_state <= 1'b0;
            light      <= 1'b0;
            occupied   <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            // Occupancy timer runs in both occupied phases and saturates; the
            // alarm is raised on the edge the count reaches OCC_TIMEOUT.
            if (state == OCCUPIED || state == FLUSHED) begin
                if (occ_tmr != OCC_MAX) begin
                    occ_tmr <= occ_tmr + OT_W'(1);
                end
                if (occ_tmr == OCC_LAST) begin
                    alarm <= 1'b1;
                end
            end

            case (state)
                VACANT: begin
                    if (flush_out && water_ok) begin
                        state    <= ARMED;
                        door_tmr <= '0;
                    end
                end

                ARMED: begin
                    // Low water aborts arming before a door request is honoured.
                    if (!water_ok) begin
                        state <= VACANT;
                    end else if (door_open_outside) begin
                        state      <= ENTER;
                        door_tmr   <= '0;
                        door_state <= 1'b1;
                        light      <= 1'b1;
                        occupied   <= 1'b1;
                    end else if (door_tmr == DOOR_LAST) begin
                        state <= VACANT;
                    end else begin
                        door_tmr <= door_tmr + DT_W'(1);
                    end
                end

                ENTER: begin
                    if (door_tmr == DOOR_LAST) begin
                        state      <= OCCUPIED;
                        door_state <= 1'b0;
                        occ_tmr    <= '0;
                    end else begin
                        door_tmr <= door_tmr + DT_W'(1);
                    end
                end

                OCCUPIED: begin
                    // Inside door request deliberately ignored until flushed.
                    if (flush_in) begin
                        state <= FLUSHED;
                    end
                end

                FLUSHED: begin
                    if (door_open_inside) begin
                        state      <= EXIT;
                        door_tmr   <= '0;
                        door_state <= 1'b1;
                    end
                end

                EXIT: begin
                    if (door_tmr == DOOR_LAST) begin
                        state      <= VACANT;
                        door_state <= 1'b0;
                        light      <= 1'b0;
                        occupied   <= 1'b0;
                        alarm      <= 1'b0;
                    end else begin
                        door_tmr <= door_tmr + DT_W'(1);
                    end
                end

                default: begin
                    state      <= VACANT;
                    door_state <= 1'b0;
                    light      <= 1'b0;
                    occupied   <= 1'b0;
                    alarm      <= 1'b0;
                end
            endcase
        end
    end

endmodule : restroom_stall_fsm

// File: rtl/smart_restroom_ctrl.sv
// -----------------------------------------------------------------------------
// smart_restroom_ctrl
//   Multi-stall restroom controller. One restroom_stall_fsm per stall, a
//   hysteretic tank refill request (motor_on), a combinational count of
//   VACANT stalls and, optionally, a saturating count of completed entries.
//
//   Optional feature macro: RESTROOM_USAGE_CNT_EN adds the usage_cnt port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush_out           [NUM_STALLS] outside pre-entry flush buttons
//   door_open_outside   [NUM_STALLS] outside door requests
//   flush_in            [NUM_STALLS] inside flush buttons
//   door_open_inside    [NUM_STALLS] inside door requests
//   water_level         [WL_W] unsigned tank level
//   door_state          [NUM_STALLS] 1 = door open
//   light               [NUM_STALLS] stall lights
//   occupied            [NUM_STALLS] occupancy indicators
//   alarm               [NUM_STALLS] occupancy timeout alarms
//   motor_on            refill request (registered, hysteretic)
//   vacant_cnt          number of stalls in VACANT (combinational)
//   usage_cnt           [16] completed entries (macro only, saturating)
// -----------------------------------------------------------------------------
module smart_restroom_ctrl
    import restroom_pkg::*;
#(
    parameter int NUM_STALLS  = 4,
    parameter int DOOR_CYC    = 8,
    parameter int OCC_TIMEOUT = 1024,
    parameter int WL_W        = 8,
    parameter int LOW_THR     = 64,
    parameter int HIGH_THR    = 192
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_STALLS-1:0]             flush_out,
    input  logic [NUM_STALLS-1:0]             door_open_outside,
    input  logic [NUM_STALLS-1:0]             flush_in,
    input  logic [NUM_STALLS-1:0]             door_open_inside,
    input  logic [WL_W-1:0]                   water_level,
    output logic [NUM_STALLS-1:0]             door_state,
    output logic [NUM_STALLS-1:0]             light,
    output logic [NUM_STALLS-1:0]             occupied,
    output logic [NUM_STALLS-1:0]             alarm,
    output logic                              motor_on,
    output logic [$clog2(NUM_STALLS+1)-1:0]   vacant_cnt
`ifdef RESTROOM_USAGE_CNT_EN
    ,
    output logic [USAGE_W-1:0]                usage_cnt
`endif
);

    localparam int VC_W = $clog2(NUM_STALLS + 1);

    logic         water_ok;
    stall_state_t stall_state [NUM_STALLS];

`ifdef RESTROOM_USAGE_CNT_EN
    logic [NUM_STALLS-1:0] enter_done;
`endif

    // Arming is allowed only while no refill is requested.
    assign water_ok = !motor_on;

    // Set below LOW_THR, clear at/above HIGH_THR, hold in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_on <= 1'b0;
        end else if (water_level < WL_W'(LOW_THR)) begin
            motor_on <= 1'b1;
        end else if (water_level >= WL_W'(HIGH_THR)) begin
            motor_on <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_STALLS; g++) begin : g_stall
        restroom_stall_fsm #(
            .DOOR_CYC    (DOOR_CYC),
            .OCC_TIMEOUT (OCC_TIMEOUT)
        ) u_fsm (
`ifdef RESTROOM_USAGE_CNT_EN
            .enter_done        (enter_done[g]),
`endif
            .clk               (clk),
            .rst               (rst),
            .water_ok          (water_ok),
            .flush_out         (flush_out[g]),
            .door_open_outside (door_open_outside[g]),
            .flush_in          (flush_in[g]),
            .door_open_inside  (door_open_inside[g]),
            .door_state        (door_state[g]),
            .light             (light[g]),
            .occupied          (occupied[g]),
            .alarm             (alarm[g]),
            .state             (stall_state[g])
        );
    end

    always_comb begin
        vacant_cnt = '0;
        for (int i = 0; i < NUM_STALLS; i++) begin
            vacant_cnt = vacant_cnt + VC_W'(stall_state[i] == VACANT);
        end
    end

`ifdef RESTROOM_USAGE_CNT_EN
    logic [VC_W-1:0]    enter_n;
    logic [USAGE_W:0]   usage_sum;

    always_comb begin
        enter_n = '0;
        for (int i = 0; i < NUM_STALLS; i++) begin
            enter_n = enter_n + VC_W'(enter_done[i]);
        end
    end

    // One extra bit catches the carry so the counter can clamp at all-ones.
    assign usage_sum = {1'b0, usage_cnt} + (USAGE_W + 1)'(enter_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usage_cnt <= '0;
        end else if (usage_sum[USAGE_W]) begin
            usage_cnt <= '1;
        end else begin
            usage_cnt <= usage_sum[USAGE_W-1:0];
        end
    end
`endif

endmodule : smart_restroom_ctrl

// File: tb/tb_smart_restroom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smart_restroom_ctrl
//   Directed bench for smart_restroom_ctrl (4 stalls, DOOR_CYC=8,
//   OCC_TIMEOUT=1024). Drivers update a hand-maintained expected output image
//   and push it into exp_q right after each rising edge; the monitor pops and
//   compares on the falling edge. RESTROOM_USAGE_CNT_EN extends the image
//   with usage_cnt.
// -----------------------------------------------------------------------------
module tb_smart_restroom_ctrl;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int OT = 1024;

`ifdef RESTROOM_USAGE_CNT_EN
    localparam int VW = 4 * N + 1 + 3 + 16;
`else
    localparam int VW = 4 * N + 1 + 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] fo, doo, fi, doi;
    logic [7:0]   wl;
    logic [N-1:0] door_state, light, occupied, alarm;
    logic         motor_on;
    logic [2:0]   vacant_cnt;
`ifdef RESTROOM_USAGE_CNT_EN
    logic [15:0]  usage_cnt;
`endif

    smart_restroom_ctrl #(
        .NUM_STALLS  (N),
        .DOOR_CYC    (DC),
        .OCC_TIMEOUT (OT),
        .WL_W        (8),
        .LOW_THR     (64),
        .HIGH_THR    (192)
    ) dut (
`ifdef RESTROOM_USAGE_CNT_EN
        .usage_cnt         (usage_cnt),
`endif
        .clk               (clk),
        .rst               (rst),
        .flush_out         (fo),
        .door_open_outside (doo),
        .flush_in          (fi),
        .door_open_inside  (doi),
        .water_level       (wl),
        .door_state        (door_state),
        .light             (light),
        .occupied          (occupied),
        .alarm             (alarm),
        .motor_on          (motor_on),
        .vacant_cnt        (vacant_cnt)
    );

    // ---------------- expected model ----------------
    logic [N-1:0] e_door, e_light, e_occ, e_alarm, e_vacm;
    logic         e_motor;
`ifdef RESTROOM_USAGE_CNT_EN
    logic [15:0]  e_use;
`endif

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    logic [VW-1:0] act;
    int            checks = 0;
    int            errors = 0;

`ifdef RESTROOM_USAGE_CNT_EN
    assign act = {door_state, light, occupied, alarm, motor_on, vacant_cnt, usage_cnt};
`else
    assign act = {door_state, light, occupied, alarm, motor_on, vacant_cnt};
`endif

    function automatic logic [VW-1:0] exp_vec();
        logic [2:0] vac;
        vac = 3'($countones(e_vacm));
`ifdef RESTROOM_USAGE_CNT_EN
        return {e_door, e_light, e_occ, e_alarm, e_motor, vac, e_use};
`else
        return {e_door, e_light, e_occ, e_alarm, e_motor, vac};
`endif
    endfunction

    task automatic model_reset();
        e_door  = '0;
        e_light = '0;
        e_occ   = '0;
        e_alarm = '0;
        e_vacm  = '1;
        e_motor = 1'b0;
`ifdef RESTROOM_USAGE_CNT_EN
        e_use   = '0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name);
        exp_q.push_back(exp_vec());
        name_q.push_back(name);
    endtask

    // Arm then enter the stalls in m; with both=1 the door request is already
    // present in VACANT, which must only arm.
    task automatic enter_stall(input logic [N-1:0] m, input bit both);
        fo = m;
        if (both) doo = m;
        tick();
        e_vacm &= ~m;
        expect_now("arm");
        fo  = '0;
        doo = m;
        tick();
        e_door  |= m;
        e_light |= m;
        e_occ   |= m;
        expect_now("enter_open");
        doo = '0;
        repeat (DC - 1) begin
            tick();
            expect_now("enter_hold");
        end
        tick();
        e_door &= ~m;
`ifdef RESTROOM_USAGE_CNT_EN
        e_use = e_use + 16'($countones(m));
`endif
        expect_now("enter_done");
    endtask

    task automatic exit_stall(input logic [N-1:0] m);
        fi = m;
        tick();
        expect_now("flushed");
        fi  = '0;
        doi = m;
        tick();
        e_door |= m;
        expect_now("exit_open");
        doi = '0;
        repeat (DC - 1) begin
            tick();
            expect_now("exit_hold");
        end
        tick();
        e_door  &= ~m;
        e_light &= ~m;
        e_occ   &= ~m;
        e_alarm &= ~m;
        e_vacm  |= m;
        expect_now("exit_done");
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [VW-1:0] mon_e;
    string         mon_n;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h", mon_n, act, mon_e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        fo  = '0;
        doo = '0;
        fi  = '0;
        doi = '0;
        wl  = 8'd200;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_now("reset_hold");
        rst = 1'b0;
        tick();
        expect_now("reset_release");

        // Stall 0 full cycle
        enter_stall(4'b0001, 1'b0);
        exit_stall(4'b0001);

        // Stall 3 occupied before the water drops
        enter_stall(4'b1000, 1'b0);
        wl = 8'd100;
        tick();
        expect_now("motor_hold_mid");

        // Arm stall 1, then low water aborts it one cycle after motor_on rises
        fo = 4'b0010;
        tick();
        fo = '0;
        e_vacm &= ~4'b0010;
        expect_now("arm_s1");
        wl = 8'd50;
        tick();
        e_motor = 1'b1;
        expect_now("motor_set");
        tick();
        e_vacm |= 4'b0010;
        expect_now("armed_abort");
        fo = 4'b0010;
        repeat (3) begin
            tick();
            expect_now("arm_blocked");
        end
        fo = '0;
        wl = 8'd150;
        tick();
        expect_now("motor_hysteresis");
        wl = 8'd192;
        tick();
        e_motor = 1'b0;
        expect_now("motor_clear");
        exit_stall(4'b1000);

        // Stall 2 occupancy timeout
        enter_stall(4'b0100, 1'b0);
        doi = 4'b0100;
        tick();
        doi = '0;
        expect_now("inside_ignored");
        repeat (OT - 2) tick();
        expect_now("pre_alarm");
        tick();
        e_alarm |= 4'b0100;
        expect_now("alarm_set");
        repeat (5) tick();
        expect_now("alarm_sticky");
        exit_stall(4'b0100);

        // All stalls enter together, with door request present in VACANT
        enter_stall(4'b1111, 1'b1);
        exit_stall(4'b0111);

        // ARMED window expires without a door request
        fo = 4'b0001;
        tick();
        fo = '0;
        e_vacm &= ~4'b0001;
        expect_now("arm_window_start");
        repeat (DC - 1) tick();
        expect_now("arm_window_end");
        tick();
        e_vacm |= 4'b0001;
        expect_now("arm_timeout");

        // Asynchronous reset while stall 3 is in EXIT
        fi = 4'b1000;
        tick();
        fi = '0;
        expect_now("s3_flushed");
        doi = 4'b1000;
        tick();
        doi = '0;
        e_door |= 4'b1000;
        expect_now("s3_exit");
        tick();
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        expect_now("async_reset");
        tick();
        rst = 1'b0;
        tick();
        expect_now("post_reset");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_smart_restroom_ctrl
